// File: rtl/bp_pkg.sv
// Shared encodings for the branch predictor / resolver.
// Branch, jump and PC-select codes plus a clog2 helper.
package bp_pkg;

    localparam logic [2:0] BR_NONE = 3'b000;
    localparam logic [2:0] BR_BEQ  = 3'b001;
    localparam logic [2:0] BR_BNE  = 3'b010;
    localparam logic [2:0] BR_BLT  = 3'b011;
    localparam logic [2:0] BR_BGE  = 3'b100;

    localparam logic [1:0] J_JAL  = 2'b01;
    localparam logic [1:0] J_JALR = 2'b10;

    localparam logic [1:0] PCS_SEQ  = 2'b00;
    localparam logic [1:0] PCS_IMM  = 2'b01;
    localparam logic [1:0] PCS_JALR = 2'b10;
    localparam logic [1:0] PCS_UNDO = 2'b11;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) r++;
        return r;
    endfunction

endpackage

// File: rtl/bht_table.sv
// Branch history table: saturating counters, one read port
// and one saturating-update port; no read/write bypass.
module bht_table
    import bp_pkg::*;
#(
    parameter  int DEPTH = 64,
    parameter  int CNT_W = 2,
    localparam int IW    = clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [IW-1:0] ridx,
    output logic          rmsb,
    input  logic          we,
    input  logic [IW-1:0] widx,
    input  logic          inc
);

    localparam logic [CNT_W-1:0] WNT  = CNT_W'((1 << (CNT_W - 1)) - 1);
    localparam logic [CNT_W-1:0] CMAX = '1;

    logic [CNT_W-1:0] cnt [DEPTH];

    assign rmsb = cnt[ridx][CNT_W-1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) cnt[i] <= WNT;
        end else if (we) begin
            if (inc && cnt[widx] != CMAX)
                cnt[widx] <= cnt[widx] + 1'b1;
            else if (!inc && cnt[widx] != '0)
                cnt[widx] <= cnt[widx] - 1'b1;
        end
    end

endmodule

// File: rtl/branch_predict_unit.sv
// EX branch/jump resolution with a BHT-based Decode predictor.
// BP_STATS_EN adds branch and mispredict counters.
module branch_predict_unit
    import bp_pkg::*;
#(
    parameter int XLEN      = 32,
    parameter int BHT_DEPTH = 64,
    parameter int CNT_W     = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [XLEN-1:0] pcD,
    input  logic            isBranchD,
    output logic            predTakenD,
    input  logic [XLEN-1:0] pcE,
    input  logic            validE,
    input  logic            stallE,
    input  logic [2:0]      branchE,
    input  logic [1:0]      jumpE,
    input  logic            zero,
    input  logic            neg,
    input  logic            predTakenE,
    output logic [1:0]      PCSrcE,
    output logic            mispredictE
`ifdef BP_STATS_EN
    ,
    output logic [31:0]     statBranches,
    output logic [31:0]     statMispredicts
`endif
);

    localparam int IW = clog2(BHT_DEPTH);

    logic rmsb;
    logic takenE;
    logic condE;
    logic updE;
    logic unused_pc;

    assign unused_pc = ^{pcD[XLEN-1:IW+2], pcD[1:0],
                         pcE[XLEN-1:IW+2], pcE[1:0]};

    assign predTakenD = isBranchD & rmsb;
    assign condE = (branchE != BR_NONE) && (branchE <= BR_BGE);
    assign updE  = validE & ~stallE & condE;

    always_comb begin
        takenE = 1'b0;
        case (branchE)
            BR_BEQ:  takenE = zero;
            BR_BNE:  takenE = ~zero;
            BR_BLT:  takenE = neg;
            BR_BGE:  takenE = zero | ~neg;
            default: takenE = 1'b0;
        endcase
    end

    // Correct taken predictions were already redirected in Decode.
    always_comb begin
        PCSrcE      = PCS_SEQ;
        mispredictE = 1'b0;
        if (validE) begin
            if (branchE == BR_NONE) begin
                if (jumpE == J_JAL) begin
                    PCSrcE      = PCS_IMM;
                    mispredictE = 1'b1;
                end else if (jumpE == J_JALR) begin
                    PCSrcE      = PCS_JALR;
                    mispredictE = 1'b1;
                end
            end else if (takenE != predTakenE) begin
                PCSrcE      = takenE ? PCS_IMM : PCS_UNDO;
                mispredictE = 1'b1;
            end
        end
    end

    bht_table #(
        .DEPTH (BHT_DEPTH),
        .CNT_W (CNT_W)
    ) u_bht (
        .clk   (clk),
        .rst_n (rst_n),
        .ridx  (pcD[IW+1:2]),
        .rmsb  (rmsb),
        .we    (updE),
        .widx  (pcE[IW+1:2]),
        .inc   (takenE)
    );

`ifdef BP_STATS_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            statBranches    <= '0;
            statMispredicts <= '0;
        end else if (updE) begin
            statBranches <= statBranches + 32'd1;
            if (mispredictE)
                statMispredicts <= statMispredicts + 32'd1;
        end
    end
`endif

endmodule
